// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder.
// Stage count and parameter legality live here.
package pipelined_adder_pkg;

  function automatic int num_stages(
    input int width,
    input int chunk
  );
    return (chunk >= 1) ? width / chunk : 1;
  endfunction

  function automatic bit params_ok(
    input int width,
    input int chunk
  );
    return (chunk >= 1) && (width >= chunk) &&
           (width % chunk == 0);
  endfunction

endpackage

// File: rtl/ripple_carry_n_bit_adder.sv
// Combinational N-bit ripple-carry adder for one pipeline chunk.
// Also exports the carry into the MSB for overflow detection.
module ripple_carry_n_bit_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C0,
  output logic [N-1:0] S,
  output logic         Cn,
  output logic         Cm
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = C0;
    for (int i = 0; i < N; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign Cn = c[N];
  assign Cm = c[N-1];

endmodule

// File: rtl/pipelined_ripple_carry_adder.sv
// Pipelined add/sub: one CHUNK-wide ripple stage per register.
// Operands skew in, sum chunks deskew out, global stall.
module pipelined_ripple_carry_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int L = num_stages(WIDTH, CHUNK);

  if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("WIDTH must be a positive multiple of CHUNK");
  end

  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < L; k++) begin : g_stg
    localparam int IW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic [SW-1:0]    s_d;
    logic [SW-1:0]    s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign a_in = A;
      assign b_in = SUB ? ~B : B;
      assign c_in = SUB | Cin;
      assign v_in = in_valid;
      assign s_d  = sum;
    end else begin : g_body
      assign a_in = g_stg[k-1].g_skew.a_q;
      assign b_in = g_stg[k-1].g_skew.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
      assign s_d  = {sum, g_stg[k-1].s_q};
    end

    // data only moves with a real operation, so bubbles keep S stable
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= cout;
          s_q <= s_d;
        end
      end
    end

    if (k < L - 1) begin : g_skew
      logic [IW-CHUNK-1:0] a_q;
      logic [IW-CHUNK-1:0] b_q;

      ripple_carry_n_bit_adder #(
        .N (CHUNK)
      ) u_add (
        .A  (a_in[CHUNK-1:0]),
        .B  (b_in[CHUNK-1:0]),
        .C0 (c_in),
        .S  (sum),
        .Cn (cout),
        .Cm ()
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && v_in) begin
          a_q <= a_in[IW-1:CHUNK];
          b_q <= b_in[IW-1:CHUNK];
        end
      end
    end else begin : g_last
      logic cm;
      logic ovf_q;

      ripple_carry_n_bit_adder #(
        .N (CHUNK)
      ) u_add (
        .A  (a_in[CHUNK-1:0]),
        .B  (b_in[CHUNK-1:0]),
        .C0 (c_in),
        .S  (sum),
        .Cn (cout),
        .Cm (cm)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall && v_in) begin
          ovf_q <= cm ^ cout;
        end
      end
    end
  end

  assign out_valid = g_stg[L-1].v_q;
  assign S         = g_stg[L-1].s_q;
  assign Cout      = g_stg[L-1].c_q;
  assign OVF       = g_stg[L-1].g_last.ovf_q;

endmodule
